mul_add_seq: RTL and testbench

MUL_ADD_SEQ -- requirements
Module: mul_add_seq

---
 rtl/mul_add_seq_pkg.sv | 18 +
 rtl/mul_add_seq_adder_32bit.sv | 21 ++
 rtl/mul_add_seq.sv | 138 +++++++++++++
 tb/tb_mul_add_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mul_add_seq_pkg.sv
// Shared constants and types for the sequential multiply-add block.
//   WIDTH_DEF : default operand width
//   ITERS     : number of shift-add iterations in MUL
//   CNT_W     : iteration counter width
//   state_t   : one-hot FSM state encoding (IDLE, MUL, FIX)
package mul_add_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ITERS     = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    MUL  = 3'b010,
    FIX  = 3'b100
  } state_t;

endpackage

// File: rtl/mul_add_seq_adder_32bit.sv
// Ripple-style WIDTH-bit adder with carry in/out, used in chained pairs
// to build wider additions.
//   i_a, i_b : addends
//   i_cin    : carry in
//   o_sum    : WIDTH-bit sum
//   o_cout   : carry out
module adder_32bit
  import mul_add_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + (WIDTH+1)'(i_cin);

endmodule

// File: rtl/mul_add_seq.sv
// Sequential signed multiply-add: computes q*d + r over 32 shift-add
// cycles plus one fix-up cycle, with a hold-until-ready handshake.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_quotient     : signed multiplicand q
//   i_divisor      : signed multiplier d
//   i_remainder    : signed addend r
//   i_start        : request, held until o_ready is seen
//   o_ready        : result valid (ready flag AND i_start)
//   o_dividend     : low WIDTH bits of q*d+r
//   o_product      : full 2*WIDTH-bit q*d+r
//   o_ovf          : result does not fit in signed WIDTH bits
module mul_add_seq
  import mul_add_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_quotient,
  input  logic [WIDTH-1:0]   i_divisor,
  input  logic [WIDTH-1:0]   i_remainder,
  input  logic               i_start,
  output logic               o_ready,
  output logic [WIDTH-1:0]   o_dividend,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_ovf
);

  state_t             state;
  logic               ready;
  logic               sign;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   d_mag;

  logic [2*WIDTH-1:0] add_a;
  logic [2*WIDTH-1:0] add_b;
  logic               add_cin;
  logic [2*WIDTH-1:0] add_sum;
  logic               carry_lo;
  logic               carry_unused;
  logic [WIDTH:0]     top_bits;

  // Unsigned magnitudes: the most negative value maps to 2^(WIDTH-1).
  assign q_mag = i_quotient[WIDTH-1] ? (~i_quotient + WIDTH'(1)) : i_quotient;
  assign d_mag = i_divisor[WIDTH-1]  ? (~i_divisor  + WIDTH'(1)) : i_divisor;

  // FIX folds negate and remainder add into one pass:
  // -acc + r == ~acc + r + 1, so the +1 rides in on the carry input.
  always_comb begin
    add_a   = acc;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      MUL: add_b = mplier[0] ? mcand : '0;
      FIX: begin
        add_a   = sign ? ~acc : acc;
        add_b   = {{WIDTH{rem[WIDTH-1]}}, rem};
        add_cin = sign;
      end
      default: ;
    endcase
  end

  adder_32bit #(.WIDTH(WIDTH)) u_add_lo (
    .i_a    (add_a[WIDTH-1:0]),
    .i_b    (add_b[WIDTH-1:0]),
    .i_cin  (add_cin),
    .o_sum  (add_sum[WIDTH-1:0]),
    .o_cout (carry_lo)
  );

  adder_32bit #(.WIDTH(WIDTH)) u_add_hi (
    .i_a    (add_a[2*WIDTH-1:WIDTH]),
    .i_b    (add_b[2*WIDTH-1:WIDTH]),
    .i_cin  (carry_lo),
    .o_sum  (add_sum[2*WIDTH-1:WIDTH]),
    .o_cout (carry_unused)
  );

  // Sign bit of the narrow result plus every bit above it must agree.
  assign top_bits = add_sum[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ready      <= 1'b0;
      sign       <= 1'b0;
      mplier     <= '0;
      rem        <= '0;
      mcand      <= '0;
      acc        <= '0;
      cnt        <= '0;
      o_dividend <= '0;
      o_product  <= '0;
      o_ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ready) begin
            if (!i_start) ready <= 1'b0;
          end else if (i_start) begin
            mcand  <= {{WIDTH{1'b0}}, q_mag};
            mplier <= d_mag;
            sign   <= i_quotient[WIDTH-1] ^ i_divisor[WIDTH-1];
            rem    <= i_remainder;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          acc    <= add_sum;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITERS - 1)) state <= FIX;
        end
        FIX: begin
          o_product  <= add_sum;
          o_dividend <= add_sum[WIDTH-1:0];
          o_ovf      <= ~((&top_bits) | ~(|top_bits));
          ready      <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready = ready & i_start;

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed testbench for mul_add_seq with a scoreboard of expected results.
module tb_mul_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] q = '0;
  logic [31:0] d = '0;
  logic [31:0] r = '0;
  logic        o_ready;
  logic [31:0] o_dividend;
  logic [63:0] o_product;
  logic        o_ovf;

  typedef struct {
    logic [31:0] div;
    logic [63:0] prod;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  mul_add_seq #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_quotient  (q),
    .i_divisor   (d),
    .i_remainder (r),
    .i_start     (start),
    .o_ready     (o_ready),
    .o_dividend  (o_dividend),
    .o_product   (o_product),
    .o_ovf       (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    exp_t   e;
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
    e.prod = p;
    e.div  = p[31:0];
    e.ovf  = (p > MAXP) || (p < MINN);
    return e;
  endfunction

  // Drive a request at a negedge; ready must already be clear.
  task automatic launch(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
    @(negedge clk);
    q = a; d = b; r = c; start = 1'b1;
    sb.push_back(model(a, b, c));
    #1 check({tag, "_ready_low_at_req"}, o_ready, 0);
  endtask

  // Count edges until o_ready; scramble operands after accept, optionally
  // glitch start during MUL, then compare against the scoreboard head.
  task automatic wait_result(input string tag, input bit glitch);
    int   n;
    bit   seen;
    exp_t e;
    n = 0; seen = 0;
    while (n < 100 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (o_ready) seen = 1;
      else begin
        if (n == 1) begin q = $urandom; d = $urandom; r = $urandom; end
        if (glitch && n == 9) begin start = 1'b0; q = 32'd5; end
        if (glitch && n == 10) start = 1'b1;
      end
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_latency"}, n, 34);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_dividend"}, o_dividend, e.div);
      check({tag, "_product"}, o_product, e.prod);
      check({tag, "_ovf"}, o_ovf, e.ovf);
    end else check({tag, "_sb_empty"}, 1, 0);
  endtask

  // Keep start high past completion, then drop it.
  task automatic hold_release(input string tag, input int cycles);
    logic [63:0] p;
    p = o_product;
    repeat (cycles) begin
      @(posedge clk); #1;
      check({tag, "_hold_ready"}, o_ready, 1);
      check({tag, "_hold_product"}, o_product, p);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    exp_t dummy;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dividend", o_dividend, 0);
    check("rst_product", o_product, 0);
    check("rst_ovf", o_ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    launch("basic", 32'd7, 32'd3, 32'd2);
    wait_result("basic", 0);
    check("basic_exact_div", o_dividend, 64'd23);
    hold_release("basic", 1);

    launch("mixed", 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFE);
    wait_result("mixed", 0);
    check("mixed_exact_prod", o_product, 64'hFFFF_FFFF_FFFF_FFE9);
    hold_release("mixed", 1);

    launch("ovf_corner", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_result("ovf_corner", 0);
    check("ovf_exact_prod", o_product, 64'h0000_0000_8000_0000);
    check("ovf_exact_flag", o_ovf, 1);
    hold_release("ovf_corner", 1);

    // Start glitch during MUL, then hold 5 cycles past completion.
    launch("handshake", 32'd11, 32'd13, 32'd4);
    wait_result("handshake", 1);
    hold_release("handshake", 5);

    // Reset mid-operation.
    launch("rst_mid", 32'd1234, 32'd5678, 32'd9);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_ready", o_ready, 0);
    check("rstmid_dividend", o_dividend, 0);
    check("rstmid_product", o_product, 0);
    check("rstmid_ovf", o_ovf, 0);
    dummy = sb.pop_back();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;

    launch("neg_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    wait_result("neg_neg", 0);
    check("neg_neg_exact_div", o_dividend, 64'd1);
    hold_release("neg_neg", 1);

    launch("zero_max", 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_result("zero_max", 0);
    hold_release("zero_max", 1);

    launch("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_result("max_max", 0);
    hold_release("max_max", 1);

    for (int i = 0; i < 3; i++) begin
      launch("rand", $urandom, $urandom_range(0, 65535), $urandom);
      wait_result("rand", 0);
      hold_release("rand", 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
